// File: rtl/sterownik_trybu.sv
// Mode controller for the mod-12 counter: four raw buttons -> sync, debounce, edge detect -> mode FSM.
// Optional idle auto-stop in PLUS/MINUS is compiled in with `define AUTO_STOP_EN.
module sterownik_trybu #(
    parameter int DEB_CYCLES       = 1000,
    parameter int DEB_W            = 10,
    parameter int AUTO_STOP_CYCLES = 4096,
    parameter int TIMER_W          = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_plus,
    input  logic       btn_minus,
    input  logic       btn_stop,
    input  logic       btn_dziel,
    output logic [1:0] tryb,
    output logic       zdarzenie
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_PLUS  = 2'b01,
        ST_MINUS = 2'b10,
        ST_DZIEL = 2'b11
    } tryb_e;

    localparam int B_PLUS  = 0;
    localparam int B_MINUS = 1;
    localparam int B_STOP  = 2;
    localparam int B_DZIEL = 3;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [3:0]       btn_raw;
    logic [3:0]       s1_q, s1_d;
    logic [3:0]       s2_q, s2_d;
    logic [3:0]       deb_q, deb_d;
    logic [3:0]       deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0] cnt_q [4];
    logic [DEB_W-1:0] cnt_d [4];
    logic [3:0]       press;

    tryb_e            state_q, state_d;
    tryb_e            prev_q, prev_d;
    logic             zdarzenie_q, zdarzenie_d;

    assign btn_raw = {btn_dziel, btn_stop, btn_minus, btn_plus};

    // Debounce: a mismatching level must persist DEB_CYCLES cycles before it is accepted.
    always_comb begin
        s1_d       = btn_raw;
        s2_d       = s1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

`ifdef AUTO_STOP_EN
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_STOP_CYCLES - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timer_run;
    logic               timeout;

    assign timer_run = (state_q == ST_PLUS) || (state_q == ST_MINUS);
    assign timeout   = timer_run && (timer_q == TIMER_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = ^(AUTO_STOP_CYCLES ^ TIMER_W);
`endif

    // Mode FSM: stop > dziel > minus > plus; DZIEL falls back to the recorded mode after one cycle.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        if (press[B_STOP]) begin
            state_d = ST_STOP;
        end else if (press[B_DZIEL]) begin
            state_d = ST_DZIEL;
            if (state_q != ST_DZIEL) begin
                prev_d = state_q;
            end
        end else if (press[B_MINUS]) begin
            state_d = ST_MINUS;
        end else if (press[B_PLUS]) begin
            state_d = ST_PLUS;
        end else if (state_q == ST_DZIEL) begin
            state_d = prev_q;
`ifdef AUTO_STOP_EN
        end else if (timeout) begin
            state_d = ST_STOP;
`endif
        end
        zdarzenie_d = (state_d != state_q);
    end

`ifdef AUTO_STOP_EN
    always_comb begin
        if ((press != 4'b0000) || (state_d != state_q) || !timer_run) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            state_q     <= ST_STOP;
            prev_q      <= ST_STOP;
            zdarzenie_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q     <= state_d;
            prev_q      <= prev_d;
            zdarzenie_q <= zdarzenie_d;
        end
    end

    assign tryb      = state_q;
    assign zdarzenie = zdarzenie_q;

endmodule

// File: tb/tb_sterownik_trybu.sv
// Directed bench for sterownik_trybu with DEB_CYCLES=4 (press visible on tryb 7 edges after raw rise).
module tb_sterownik_trybu;

    localparam logic [3:0] M_PLUS  = 4'b0001;
    localparam logic [3:0] M_MINUS = 4'b0010;
    localparam logic [3:0] M_STOP  = 4'b0100;
    localparam logic [3:0] M_DZIEL = 4'b1000;

    logic       clk;
    logic       reset;
    logic [3:0] btns;
    logic [1:0] tryb;
    logic       zdarzenie;

    int n_total;
    int n_bad;

    sterownik_trybu #(
        .DEB_CYCLES      (4),
        .DEB_W           (3),
        .AUTO_STOP_CYCLES(16),
        .TIMER_W         (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_plus (btns[0]),
        .btn_minus(btns[1]),
        .btn_stop (btns[2]),
        .btn_dziel(btns[3]),
        .tryb     (tryb),
        .zdarzenie(zdarzenie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise mask, hold for 'hold' edges, then low for 'post' edges; the FSM reacts at k=7.
    task automatic run(input string tag, input logic [3:0] mask, input int hold, input int post,
                       input logic [1:0] old_m, input logic [1:0] first_m, input logic [1:0] final_m);
        logic [1:0] exp_t;
        logic       exp_z;
        btns = mask;
        for (int k = 1; k <= hold + post; k++) begin
            step();
            exp_t = (k < 7) ? old_m : ((k == 7) ? first_m : final_m);
            exp_z = (k == 7) ? (first_m != old_m) : ((k == 8) ? (final_m != first_m) : 1'b0);
            chk($sformatf("%s_tryb_k%0d", tag, k), 32'(tryb), 32'(exp_t));
            chk($sformatf("%s_zd_k%0d", tag, k), 32'(zdarzenie), 32'(exp_z));
            if (k == hold) btns = 4'b0000;
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        btns    = 4'b0000;
        reset   = 1'b1;
        step();
        chk("rst_tryb", 32'(tryb), 32'd0);
        chk("rst_zd", 32'(zdarzenie), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("idle_tryb", 32'(tryb), 32'd0);

        // Single plus press from STOP, held well past acceptance: one pulse only.
        run("plus", M_PLUS, 8, 6, 2'd0, 2'd1, 2'd1);
        run("dziel_from_plus", M_DZIEL, 8, 6, 2'd1, 2'd3, 2'd1);
        run("minus", M_MINUS, 8, 6, 2'd1, 2'd2, 2'd2);
        run("stop_plus", M_STOP | M_PLUS, 8, 6, 2'd2, 2'd0, 2'd0);

        // Three-cycle glitch on minus is filtered out.
        btns = M_MINUS;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 3) btns = 4'b0000;
            chk($sformatf("glitch_tryb_k%0d", k), 32'(tryb), 32'd0);
            chk($sformatf("glitch_zd_k%0d", k), 32'(zdarzenie), 32'd0);
        end
        run("minus_long", M_MINUS, 10, 6, 2'd0, 2'd2, 2'd2);
        run("stop", M_STOP, 8, 6, 2'd2, 2'd0, 2'd0);
        run("dziel_from_stop", M_DZIEL, 8, 6, 2'd0, 2'd3, 2'd0);
        run("dziel_minus", M_DZIEL | M_MINUS, 8, 6, 2'd0, 2'd3, 2'd0);
        run("plus2", M_PLUS, 8, 6, 2'd0, 2'd1, 2'd1);
        run("plus_same", M_PLUS, 8, 6, 2'd1, 2'd1, 2'd1);

        // Reset in the middle of a minus debounce while in PLUS.
        btns = M_MINUS;
        for (int k = 1; k <= 4; k++) step();
        chk("pre_rst_tryb", 32'(tryb), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_tryb", 32'(tryb), 32'd0);
        chk("mid_rst_zd", 32'(zdarzenie), 32'd0);
        step();
        step();
        chk("held_rst_tryb", 32'(tryb), 32'd0);
        reset = 1'b0;
        run("after_rst", M_MINUS, 8, 6, 2'd0, 2'd2, 2'd2);

        run("plus3", M_PLUS, 8, 6, 2'd2, 2'd1, 2'd1);
`ifdef AUTO_STOP_EN
        // Re-press plus (clears the idle timer at j=7); auto-stop then fires 16 edges later.
        btns = M_PLUS;
        for (int j = 1; j <= 30; j++) begin
            step();
            chk($sformatf("auto_tryb_j%0d", j), 32'(tryb), (j < 23) ? 32'd1 : 32'd0);
            chk($sformatf("auto_zd_j%0d", j), 32'(zdarzenie), (j == 23) ? 32'd1 : 32'd0);
        end
        btns = 4'b0000;
`else
        for (int j = 1; j <= 1000; j++) begin
            step();
            chk($sformatf("hold_tryb_j%0d", j), 32'(tryb), 32'd1);
            chk($sformatf("hold_zd_j%0d", j), 32'(zdarzenie), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
